// File: rtl/interrupt_ctrl_pkg.sv
// Shared constants, source indices and FSM encoding for the interrupt controller.
package interrupt_ctrl_pkg;

    localparam logic [15:0] IF_ADDR     = 16'hFF0F;
    localparam logic [15:0] IE_ADDR     = 16'hFFFF;
    localparam logic [7:0]  VECTOR_BASE = 8'h40;
    localparam int          NUM_SRC     = 5;

    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOYPAD = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } irq_state_t;

    // Each source owns an 8-byte slot above the vector base.
    function automatic logic [7:0] vector_of(input logic [2:0] idx);
        return VECTOR_BASE + {2'b00, idx, 3'b000};
    endfunction

endpackage

// File: rtl/interrupt_ctrl_if.sv
// CPU-side bus and dispatch handshake of the interrupt controller.
interface interrupt_ctrl_if;

    logic [15:0] address;
    logic [7:0]  indata;
    logic [7:0]  outdata;
    logic        load;
    logic        store;
    logic        ime;
    logic        int_ack;
    logic        irq;
    logic [7:0]  int_vector;
    logic        int_pending;

    modport master (
        output address, indata, load, store, ime, int_ack,
        input  outdata, irq, int_vector, int_pending
    );

    modport slave (
        input  address, indata, load, store, ime, int_ack,
        output outdata, irq, int_vector, int_pending
    );

endinterface

// File: rtl/interrupt_ctrl_prio_encoder.sv
// Picks the lowest set bit of the pending mask; bit 0 has the highest priority.
module irq_prio_encoder
    import interrupt_ctrl_pkg::*;
(
    input  logic [NUM_SRC-1:0] pend,
    output logic [2:0]         index,
    output logic               valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = 3'd0;
        valid = |pend;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: IF/IE registers on the CPU bus, priority selection
// and the irq/int_ack dispatch handshake with the CPU core.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
(
    input  logic               clockgb,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] int_req,
    interrupt_ctrl_if.slave    bus
);

    logic [NUM_SRC-1:0] if_q;
    logic [NUM_SRC-1:0] if_d;
    logic [NUM_SRC-1:0] if_base;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] ack_clr;
    logic [7:0]         ie_q;
    irq_state_t         state_q;
    irq_state_t         state_d;
    logic [2:0]         sel_q;
    logic [2:0]         sel_d;
    logic [7:0]         vec_q;
    logic [7:0]         vec_d;
    logic [2:0]         enc_index;
    logic               enc_valid;
    logic               if_sel;
    logic               ie_sel;

    assign if_sel = (bus.address == IF_ADDR);
    assign ie_sel = (bus.address == IE_ADDR);
    assign pend   = ie_q[NUM_SRC-1:0] & if_q;

    irq_prio_encoder u_prio (
        .pend  (pend),
        .index (enc_index),
        .valid (enc_valid)
    );

    // Read mux; drives zero when not selected because the bus is OR-combined.
    always_comb begin
        bus.outdata = 8'h00;
        if (bus.load && if_sel) begin
            bus.outdata = {3'b111, if_q};
        end else if (bus.load && ie_sel) begin
            bus.outdata = ie_q;
        end
    end

    // IF update order: CPU write, then acknowledge clear, then new requests win.
    always_comb begin
        if_base = (bus.store && if_sel) ? bus.indata[NUM_SRC-1:0] : if_q;
        if_d    = (if_base & ~ack_clr) | int_req;
    end

    // Dispatch FSM: latch the winning source in IDLE, hold it until ack or cancel.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vec_d   = vec_q;
        ack_clr = '0;
        case (state_q)
            IDLE: begin
                if (bus.ime && enc_valid) begin
                    state_d = PENDING;
                    sel_d   = enc_index;
                    vec_d   = vector_of(enc_index);
                end
            end
            PENDING: begin
                if (bus.int_ack) begin
                    ack_clr[sel_q] = 1'b1;
                    state_d        = IDLE;
                end else if (!bus.ime || !pend[sel_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, selection, vector and flag/enable registers.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            vec_q   <= VECTOR_BASE;
            if_q    <= '0;
            ie_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vec_q   <= vec_d;
            if_q    <= if_d;
            if (bus.store && ie_sel) begin
                ie_q <= bus.indata;
            end
        end
    end

    assign bus.irq         = (state_q == PENDING);
    assign bus.int_vector  = vec_q;
    assign bus.int_pending = |pend;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: scoreboard queues of expected read
// data and dispatch vectors, one task per scenario.
module tb_interrupt_ctrl;
    import interrupt_ctrl_pkg::*;

    logic       clockgb = 1'b0;
    logic       resetn;
    logic [4:0] int_req;

    interrupt_ctrl_if bus_if ();

    interrupt_ctrl dut (
        .clockgb (clockgb),
        .resetn  (resetn),
        .int_req (int_req),
        .bus     (bus_if)
    );

    always #5 clockgb = ~clockgb;

    int checks = 0;
    int passes = 0;

    logic [7:0] rd_q[$];
    logic [7:0] vec_q[$];
    logic [7:0] obs;
    logic [7:0] exp_v;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Move to just after the next rising edge.
    task automatic step();
        @(posedge clockgb);
        #1;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] d);
        bus_if.address = addr;
        bus_if.load    = 1'b1;
        #1;
        d              = bus_if.outdata;
        bus_if.load    = 1'b0;
        bus_if.address = 16'h0000;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] d);
        bus_if.address = addr;
        bus_if.indata  = d;
        bus_if.store   = 1'b1;
        step();
        bus_if.store   = 1'b0;
        bus_if.address = 16'h0000;
    endtask

    task automatic pulse_req(input logic [4:0] mask);
        int_req = mask;
        step();
        int_req = 5'b0;
    endtask

    task automatic do_ack();
        bus_if.int_ack = 1'b1;
        step();
        bus_if.int_ack = 1'b0;
    endtask

    task automatic test_reset();
        resetn         = 1'b0;
        int_req        = 5'b0;
        bus_if.address = 16'h0000;
        bus_if.indata  = 8'h00;
        bus_if.load    = 1'b0;
        bus_if.store   = 1'b0;
        bus_if.ime     = 1'b0;
        bus_if.int_ack = 1'b0;
        #23;
        resetn = 1'b1;
        step();
        rd_q.push_back(8'hE0);
        rd_q.push_back(8'h00);
        bus_read(IF_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL reset_if: actual=%h required=%h", obs, exp_v);
        else passes++;
        bus_read(IE_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL reset_ie: actual=%h required=%h", obs, exp_v);
        else passes++;
        checks++;
        if (bus_if.irq !== 1'b0) $display("[TB] FAIL reset_irq: actual=%b required=0", bus_if.irq);
        else passes++;
        checks++;
        if (bus_if.int_pending !== 1'b0) $display("[TB] FAIL reset_pending: actual=%b required=0", bus_if.int_pending);
        else passes++;
        checks++;
        if (bus_if.int_vector !== 8'h40) $display("[TB] FAIL reset_vector: actual=%h required=40", bus_if.int_vector);
        else passes++;
        bus_read(16'h1234, obs);
        checks++;
        if (obs !== 8'h00) $display("[TB] FAIL unselected_read: actual=%h required=00", obs);
        else passes++;
    endtask

    task automatic test_single();
        bus_write(IE_ADDR, 8'h04);
        bus_if.ime = 1'b1;
        rd_q.push_back(8'hE4);
        vec_q.push_back(8'h50);
        pulse_req(5'b00100);
        bus_read(IF_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL single_if_set: actual=%h required=%h", obs, exp_v);
        else passes++;
        checks++;
        if (bus_if.irq !== 1'b0) $display("[TB] FAIL single_irq_early: actual=%b required=0", bus_if.irq);
        else passes++;
        step();
        checks++;
        if (bus_if.irq !== 1'b1) $display("[TB] FAIL single_irq_rise: actual=%b required=1", bus_if.irq);
        else passes++;
        exp_v = vec_q.pop_front();
        checks++;
        if (bus_if.int_vector !== exp_v) $display("[TB] FAIL single_vector: actual=%h required=%h", bus_if.int_vector, exp_v);
        else passes++;
        rd_q.push_back(8'hE0);
        do_ack();
        checks++;
        if (bus_if.irq !== 1'b0) $display("[TB] FAIL single_irq_fall: actual=%b required=0", bus_if.irq);
        else passes++;
        bus_read(IF_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL single_if_clear: actual=%h required=%h", obs, exp_v);
        else passes++;
    endtask

    task automatic test_priority();
        bus_write(IE_ADDR, 8'h1F);
        vec_q.push_back(8'h50);
        vec_q.push_back(8'h60);
        pulse_req(5'b10100);
        step();
        exp_v = vec_q.pop_front();
        checks++;
        if (bus_if.irq !== 1'b1 || bus_if.int_vector !== exp_v)
            $display("[TB] FAIL prio_first: actual irq=%b vec=%h required irq=1 vec=%h", bus_if.irq, bus_if.int_vector, exp_v);
        else passes++;
        do_ack();
        checks++;
        if (bus_if.irq !== 1'b0) $display("[TB] FAIL prio_gap: actual=%b required=0", bus_if.irq);
        else passes++;
        step();
        exp_v = vec_q.pop_front();
        checks++;
        if (bus_if.irq !== 1'b1 || bus_if.int_vector !== exp_v)
            $display("[TB] FAIL prio_second: actual irq=%b vec=%h required irq=1 vec=%h", bus_if.irq, bus_if.int_vector, exp_v);
        else passes++;
        rd_q.push_back(8'hE0);
        do_ack();
        step();
        step();
        checks++;
        if (bus_if.irq !== 1'b0) $display("[TB] FAIL prio_quiet: actual=%b required=0", bus_if.irq);
        else passes++;
        bus_read(IF_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL prio_if_clear: actual=%h required=%h", obs, exp_v);
        else passes++;
    endtask

    task automatic test_cancel();
        bus_write(IE_ADDR, 8'h04);
        pulse_req(5'b00100);
        step();
        rd_q.push_back(8'hE0);
        bus_write(IF_ADDR, 8'h00);
        step();
        checks++;
        if (bus_if.irq !== 1'b0) $display("[TB] FAIL cancel_write: actual=%b required=0", bus_if.irq);
        else passes++;
        bus_read(IF_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL cancel_write_if: actual=%h required=%h", obs, exp_v);
        else passes++;
        pulse_req(5'b00100);
        step();
        rd_q.push_back(8'hE4);
        vec_q.push_back(8'h50);
        bus_if.ime = 1'b0;
        step();
        checks++;
        if (bus_if.irq !== 1'b0) $display("[TB] FAIL cancel_ime: actual=%b required=0", bus_if.irq);
        else passes++;
        bus_read(IF_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL cancel_ime_if: actual=%h required=%h", obs, exp_v);
        else passes++;
        bus_if.ime = 1'b1;
        step();
        exp_v = vec_q.pop_front();
        checks++;
        if (bus_if.irq !== 1'b1 || bus_if.int_vector !== exp_v)
            $display("[TB] FAIL cancel_reraise: actual irq=%b vec=%h required irq=1 vec=%h", bus_if.irq, bus_if.int_vector, exp_v);
        else passes++;
        do_ack();
    endtask

    task automatic test_back_to_back();
        pulse_req(5'b00100);
        step();
        rd_q.push_back(8'hE4);
        vec_q.push_back(8'h50);
        bus_if.int_ack = 1'b1;
        int_req        = 5'b00100;
        step();
        bus_if.int_ack = 1'b0;
        int_req        = 5'b0;
        checks++;
        if (bus_if.irq !== 1'b0) $display("[TB] FAIL b2b_irq_fall: actual=%b required=0", bus_if.irq);
        else passes++;
        bus_read(IF_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL b2b_if_kept: actual=%h required=%h", obs, exp_v);
        else passes++;
        step();
        exp_v = vec_q.pop_front();
        checks++;
        if (bus_if.irq !== 1'b1 || bus_if.int_vector !== exp_v)
            $display("[TB] FAIL b2b_reraise: actual irq=%b vec=%h required irq=1 vec=%h", bus_if.irq, bus_if.int_vector, exp_v);
        else passes++;
        do_ack();
        bus_if.ime = 1'b0;
        pulse_req(5'b00100);
        rd_q.push_back(8'hE1);
        bus_if.address = IF_ADDR;
        bus_if.indata  = 8'h00;
        bus_if.store   = 1'b1;
        int_req        = 5'b00001;
        step();
        bus_if.store   = 1'b0;
        int_req        = 5'b0;
        bus_read(IF_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL b2b_write_vs_req: actual=%h required=%h", obs, exp_v);
        else passes++;
        bus_write(IF_ADDR, 8'h00);
    endtask

    task automatic test_pending_and_reset();
        bus_if.ime = 1'b0;
        bus_write(IE_ADDR, 8'h01);
        pulse_req(5'b00001);
        checks++;
        if (bus_if.int_pending !== 1'b1) $display("[TB] FAIL pending_flag: actual=%b required=1", bus_if.int_pending);
        else passes++;
        step();
        step();
        checks++;
        if (bus_if.irq !== 1'b0) $display("[TB] FAIL pending_no_irq: actual=%b required=0", bus_if.irq);
        else passes++;
        rd_q.push_back(8'hE1);
        do_ack();
        bus_read(IF_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL idle_ack_ignored: actual=%h required=%h", obs, exp_v);
        else passes++;
        bus_if.ime = 1'b1;
        step();
        checks++;
        if (bus_if.irq !== 1'b1 || bus_if.int_vector !== 8'h40)
            $display("[TB] FAIL vblank_dispatch: actual irq=%b vec=%h required irq=1 vec=40", bus_if.irq, bus_if.int_vector);
        else passes++;
        rd_q.push_back(8'hE0);
        rd_q.push_back(8'h00);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus_if.irq !== 1'b0) $display("[TB] FAIL async_reset_irq: actual=%b required=0", bus_if.irq);
        else passes++;
        bus_read(IF_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL async_reset_if: actual=%h required=%h", obs, exp_v);
        else passes++;
        bus_read(IE_ADDR, obs);
        exp_v = rd_q.pop_front();
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL async_reset_ie: actual=%h required=%h", obs, exp_v);
        else passes++;
        resetn = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_cancel();
        test_back_to_back();
        test_pending_and_reset();
        checks++;
        if (rd_q.size() != 0 || vec_q.size() != 0)
            $display("[TB] FAIL scoreboard_drain: actual rd=%0d vec=%0d required 0", rd_q.size(), vec_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
